// File: rtl/md_unit_if.sv
// Multiply/divide unit port bundle: E-stage request/operands in, busy and HI/LO read data out.
// Handshake: start qualifies op/A/B for one edge; it is only honoured while busy is low.
interface md_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hilo_sel;
    logic        busy;
    logic [31:0] rd_data;

    modport master (output start, op, A, B, hilo_sel, input busy, rd_data);
    modport slave  (input start, op, A, B, hilo_sel, output busy, rd_data);
endinterface

// File: rtl/md_unit.sv
// MIPS E-stage multiply/divide unit holding HI/LO. The result is computed at issue into shadow
// registers and committed to HI/LO after a fixed busy latency, mimicking an iterative unit.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  bus,
    output logic      o_dbg_state
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]   r_hi, r_lo, r_sh_hi, r_sh_lo;
    logic          w_take_md, w_take_mthi, w_take_mtlo, w_done;

    logic [63:0]   w_prod_s, w_prod_u;
    logic          w_div_signed, w_b_zero;
    logic [31:0]   w_a_mag, w_b_mag, w_divisor, w_q_mag, w_r_mag;
    logic [31:0]   w_res_hi, w_res_lo;

    // Sign-extended 64-bit product: the low 64 bits equal the signed product.
    assign w_prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    assign w_prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    assign w_b_zero = (bus.B == 32'd0);

    always_comb begin
        w_div_signed = (bus.op == OP_DIV);
        w_a_mag      = (w_div_signed && bus.A[31]) ? (~bus.A + 32'd1) : bus.A;
        w_b_mag      = (w_div_signed && bus.B[31]) ? (~bus.B + 32'd1) : bus.B;
        // Divide-by-zero keeps HI/LO, so the divisor only needs to stay well-defined.
        w_divisor    = w_b_zero ? 32'd1 : w_b_mag;
        w_q_mag      = w_a_mag / w_divisor;
        w_r_mag      = w_a_mag % w_divisor;
        w_res_hi     = r_hi;
        w_res_lo     = r_lo;
        case (bus.op)
            OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            OP_DIV: begin
                if (!w_b_zero) begin
                    w_res_lo = (bus.A[31] ^ bus.B[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
                    w_res_hi = bus.A[31] ? (~w_r_mag + 32'd1) : w_r_mag;
                end
            end
            OP_DIVU: begin
                if (!w_b_zero) begin
                    w_res_lo = w_q_mag;
                    w_res_hi = w_r_mag;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_take_md   = 1'b0;
        w_take_mthi = 1'b0;
        w_take_mtlo = 1'b0;
        w_done      = 1'b0;
        if (r_state == S_IDLE) begin
            if (bus.start) begin
                case (bus.op)
                    OP_MULT, OP_MULTU: begin
                        w_take_md   = 1'b1;
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = CW'(MULT_CYCLES - 1);
                    end
                    OP_DIV, OP_DIVU: begin
                        w_take_md   = 1'b1;
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = CW'(DIV_CYCLES - 1);
                    end
                    OP_MTHI: w_take_mthi = 1'b1;
                    OP_MTLO: w_take_mtlo = 1'b1;
                    default: ;
                endcase
            end
        end else begin
            // Any start seen while running is dropped; the stall unit should never send one.
            if (r_cnt == '0) begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end else begin
                w_cnt_nxt = r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_sh_hi <= 32'd0;
            r_sh_lo <= 32'd0;
        end else begin
            if (w_take_md) begin
                r_sh_hi <= w_res_hi;
                r_sh_lo <= w_res_lo;
            end
            if (w_take_mthi) r_hi <= bus.A;
            if (w_take_mtlo) r_lo <= bus.A;
            if (w_done) begin
                r_hi <= r_sh_hi;
                r_lo <= r_sh_lo;
            end
        end
    end

    assign bus.busy    = (r_state == S_RUN);
    assign bus.rd_data = bus.hilo_sel ? r_hi : r_lo;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: table of arithmetic vectors plus hand-written sequences
// for MTHI/MTLO timing, ignored mid-run starts and asynchronous reset during a run.
module tb_md_unit;
    logic clk;
    logic reset;
    logic dbg_state;

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        logic        hold;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t        vecs[13];
    logic [63:0] exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        bus.hilo_sel = 1'b1;
        #1;
        h = bus.rd_data;
        bus.hilo_sel = 1'b0;
        #1;
        l = bus.rd_data;
    endtask

    task automatic check_result(input string name);
        logic [31:0] h, l;
        logic [63:0] e;
        read_hilo(h, l);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_queue: got empty scoreboard expected one entry", name);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_hi"}, h, e[63:32]);
            chk({name, "_lo"}, l, e[31:0]);
            m_hi = e[63:32];
            m_lo = e[31:0];
        end
    endtask

    // Issue one op at an edge, measure busy length, confirm old HI/LO while busy, then score.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic [63:0] exp, input string name);
        int cnt;
        logic [31:0] h, l;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom_range(0, 7));
        bus.A     = $urandom;
        bus.B     = $urandom;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 200) begin
            if (cnt == 0) begin
                read_hilo(h, l);
                chk({name, "_old_hi"}, h, m_hi);
                chk({name, "_old_lo"}, l, m_lo);
            end
            cnt++;
            @(posedge clk);
            #1;
        end
        chk({name, "_busy_len"}, 32'(cnt), 32'(n));
        check_result(name);
    endtask

    initial begin
        logic [31:0] h, l;
        int cnt, guard;

        vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 5,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{3'd2, 32'hFFFFFFFE, 32'h00000003, 5,  1'b0, 32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 10, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{3'd4, 32'h00000007, 32'h00000000, 10, 1'b1, 32'h0,        32'h0};
        vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, 32'h00000000, 32'h80000000};
        vecs[5]  = '{3'd3, 32'h00000005, 32'h00000000, 10, 1'b1, 32'h0,        32'h0};
        vecs[6]  = '{3'd4, 32'd100,      32'd7,        10, 1'b0, 32'h00000002, 32'h0000000E};
        vecs[7]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 10, 1'b0, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{3'd3, 32'hFFFFFFF8, 32'hFFFFFFFD, 10, 1'b0, 32'hFFFFFFFE, 32'h00000002};
        vecs[9]  = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5,  1'b0, 32'h3FFFFFFF, 32'h00000001};
        vecs[10] = '{3'd7, 32'h11111111, 32'h22222222, 0,  1'b1, 32'h0,        32'h0};
        vecs[11] = '{3'd0, 32'h33333333, 32'h44444444, 0,  1'b1, 32'h0,        32'h0};
        vecs[12] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  1'b0, 32'hFFFFFFFE, 32'h00000001};

        // Clock/reset
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.op       = 3'd0;
        bus.A        = 32'd0;
        bus.B        = 32'd0;
        bus.hilo_sel = 1'b0;
        #2;
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        read_hilo(h, l);
        chk("reset_hi", h, 32'd0);
        chk("reset_lo", l, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Table-driven arithmetic vectors
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].hold)
                do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].n, {m_hi, m_lo}, $sformatf("vec%0d", i));
            else
                do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].n, {vecs[i].hi, vecs[i].lo},
                      $sformatf("vec%0d", i));
        end

        // MTHI then MTLO on consecutive edges; values appear only after their edge
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd5;
        bus.A     = 32'h12345678;
        read_hilo(h, l);
        chk("mthi_no_fwd", h, m_hi);
        @(posedge clk);
        #1;
        bus.op = 3'd6;
        bus.A  = 32'h9ABCDEF0;
        chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
        read_hilo(h, l);
        chk("mthi_hi", h, 32'h12345678);
        chk("mthi_lo_kept", l, m_lo);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("mtlo_busy", {31'd0, bus.busy}, 32'd0);
        read_hilo(h, l);
        chk("mtlo_hi", h, 32'h12345678);
        chk("mtlo_lo", l, 32'h9ABCDEF0);
        m_hi = 32'h12345678;
        m_lo = 32'h9ABCDEF0;

        // MULT with MTHI and DIV starts injected mid-run: both must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd1;
        bus.A     = 32'd3;
        bus.B     = 32'd5;
        exp_q.push_back({32'd0, 32'd15});
        @(posedge clk);
        #1;
        cnt = bus.busy ? 1 : 0;
        bus.op = 3'd5;
        bus.A  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        cnt += bus.busy ? 1 : 0;
        bus.op = 3'd3;
        bus.A  = 32'd100;
        bus.B  = 32'd3;
        @(posedge clk);
        #1;
        cnt += bus.busy ? 1 : 0;
        bus.start = 1'b0;
        guard = 0;
        while (bus.busy === 1'b1 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
            if (bus.busy === 1'b1) cnt++;
        end
        chk("midrun_busy_len", 32'(cnt), 32'd5);
        check_result("midrun");
        repeat (3) @(posedge clk);
        #1;
        chk("midrun_no_restart", {31'd0, bus.busy}, 32'd0);

        // Load HI, start MULT, then reset asynchronously in the third RUN cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd5;
        bus.A     = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        bus.op = 3'd1;
        bus.A  = 32'd7;
        bus.B  = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("abort_running", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        read_hilo(h, l);
        chk("abort_hi", h, 32'd0);
        chk("abort_lo", l, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(posedge clk);
        #3;
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.op    = 3'd6;
        bus.A     = 32'h13579BDF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        read_hilo(h, l);
        chk("post_reset_mtlo", l, 32'h13579BDF);
        chk("post_reset_hi", h, 32'd0);
        m_lo = 32'h13579BDF;
        repeat (8) @(posedge clk);
        #1;
        read_hilo(h, l);
        chk("abort_never_hi", h, 32'd0);
        chk("abort_never_lo", l, 32'h13579BDF);
        do_op(3'd2, 32'h00010000, 32'h00010000, 5, {32'h00000001, 32'h00000000}, "post_reset_multu");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the five-stage MIPS pipeline.
- Executes mult, multu, div, divu, mthi and mtlo, and holds the HI/LO architectural registers.
- Drives `busy`, which the stall unit consumes to freeze D when an HI/LO-class instruction (mult/div/mt/mf) sits in D while an operation is in flight.
- Serves mfhi/mflo reads combinationally to the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- start  input  1  E-stage instruction is an MD-class op; qualifies op.
- op  input  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none).
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- hilo_sel  input  1  read select: 1 = HI, 0 = LO.
- busy  output  1  multi-cycle operation in progress.
- rd_data  output  32  hilo_sel ? HI : LO, combinational from the registers.

Behaviour:
- Reset (reset=0, asynchronous):
  - HI=0, LO=0, state=IDLE, counter=0, shadow registers=0.
  - busy=0 immediately, and rd_data=0.
- States IDLE and RUN; busy = (state==RUN), registered, no combinational path from start.
- IDLE, start=1, op in 1..4:
  - Operands are sampled at the edge; the full result goes into shadow registers sh_hi/sh_lo.
  - counter loads N-1, where N = MULT_CYCLES or DIV_CYCLES; go to RUN.
- Timing: start at edge T0 -> busy=1 for exactly N cycles (T0+1 .. T0+N).
  - At edge T0+N: HI<=sh_hi, LO<=sh_lo, state<=IDLE.
  - busy=0 and new values are visible on rd_data from T0+N onward.
- RUN: counter decrements each edge; the transition fires when counter==0.
  - HI/LO keep their old values throughout RUN, so rd_data shows old values while busy.
- Arithmetic:
  - MULT: {HI,LO} = signed 64-bit A*B.
  - MULTU: unsigned 64-bit A*B.
  - DIV: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- Divide by zero (B==0, div or divu):
  - Still busy for DIV_CYCLES.
  - HI/LO left unchanged at completion (shadow loaded with the current HI/LO).
- MTHI/MTLO in IDLE: HI<=A (resp. LO<=A) at the same edge; no busy; the other register is untouched.
- start=1 while in RUN (any op): ignored entirely.
  - The stall unit prevents this; the bench checks it as a robustness case only.
- start=1 with op 0 or 7: no effect.
- start=0: op, A and B are don't-care.
- rd_data is purely combinational from HI/LO/hilo_sel. No internal forwarding of mthi/mtlo within the same cycle: the value appears after the edge.
- Reset asserted mid-RUN: operation aborted, all state cleared at once, no partial HI/LO update.
  - On reset release, the unit sits in IDLE and accepts start on the first edge.
- Back-to-back operation: start may be accepted on the edge where busy falls is false. The RUN->IDLE edge does not sample start, so the next op starts no earlier than edge T0+N+1.

Test Plan:
- Reset low mid-simulation -> busy=0, rd_data=0 for both hilo_sel values, asynchronously within the same cycle.
- start, op=MULT, A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- start, op=DIV, A=0xFFFFFFF9 (-7), B=2 -> busy exactly 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Also check 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
  - Also check DIVU 7/0 -> HI/LO unchanged.
- MTHI A=0x12345678 at one edge, MTLO A=0x9ABCDEF0 at the next, no busy -> rd_data reads both values after the respective edges.
- Start MULT, then mid-RUN pulse start with MTHI and with DIV, then assert reset at RUN cycle 3:
  - The mid-RUN starts are ignored and the busy length is unchanged.
  - Reset clears HI/LO to 0, and the aborted result is never written.
